ay_bus_writer: RTL and testbench



---
 rtl/ay_bus_pkg.sv | 35 +++
 rtl/ay_bus_writer_if.sv | 35 +++
 rtl/ay_req_fifo.sv | 72 +++++++
 rtl/ay_bus_writer.sv | 196 +++++++++++++++++++
 tb/tb_ay_bus_writer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ay_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ay_bus_pkg
//  Description : Shared types for the AY-3-8913 style PSG register-bus writer.
//                Holds the bus mode codes for {BDIR,BC1}, the writer FSM
//                state type and the queued request record.
//  Revision    : 1.0 - initial release
// ============================================================================
package ay_bus_pkg;

  // Bus modes as {bdir, bc1}; BC2 is assumed tied high on the PSG side.
  localparam logic [1:0] MODE_INACTIVE = 2'b00;
  localparam logic [1:0] MODE_READ     = 2'b01;
  localparam logic [1:0] MODE_WRITE    = 2'b10;
  localparam logic [1:0] MODE_LATCH    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_GAP_A = 3'd2,
    ST_WRITE = 3'd3,
    ST_GAP_D = 3'd4
  } ay_state_e;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } ay_req_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ay_bus_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ay_bus_writer_if
//  Description : Request port plus PSG bus pins of the bus writer.
//                master : host/sequencer side (issues requests, watches bus)
//                slave  : the writer itself (accepts requests, drives bus)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ay_bus_writer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               req_valid;
  logic               req_ready;
  logic [3:0]         req_addr;
  logic [7:0]         req_data;
  logic [7:0]         bus_da;
  logic               bus_bdir;
  logic               bus_bc1;
  logic               busy;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, bus_da, bus_bdir, bus_bc1, busy, fifo_level
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, bus_da, bus_bdir, bus_bc1, busy, fifo_level
  );

endinterface
`default_nettype wire

// File: rtl/ay_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ay_req_fifo
//  Description : Synchronous request FIFO, power-of-two depth. Pushes while
//                full and pops while empty are ignored. Head is presented
//                on dout (first-word fall-through from the storage array).
//  Revision    : 1.0 - initial release
// ============================================================================
module ay_req_fifo
  import ay_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  ay_req_t                din,
  output ay_req_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  ay_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  assign full  = (r_level == C_FULL_LEVEL);
  assign empty = (r_level == '0);
  assign level = r_level;
  assign dout  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ay_bus_writer.sv
`default_nettype none
// ============================================================================
//  Module      : ay_bus_writer
//  Description : Host-side initiator for the PSG register bus. Queues
//                register-write requests and replays each as an address
//                LATCH phase followed by a data WRITE phase, each followed
//                by an INACTIVE gap. All bus pins are registered.
//                Optional build macro AY_BUS_WRITER_SKIP_LATCH_EN: remember
//                the last latched register and skip LATCH/GAP_A when the
//                next request targets the same register.
//  Revision    : 1.0 - initial release
// ============================================================================
module ay_bus_writer
  import ay_bus_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic            clk,
  input  logic            reset,
  ay_bus_writer_if.slave  bus_if
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  // Request FIFO
  ay_req_t          w_fifo_din;
  ay_req_t          w_fifo_dout;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [LVL_W-1:0] w_fifo_level;
  logic             w_pop;

  // FSM and phase timing
  ay_state_e        r_state;
  ay_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_phase_done;
  ay_req_t          r_hold;
  ay_req_t          w_hold_nxt;
  logic             w_skip;

  // Registered bus pins
  logic [7:0]       r_bus_da;
  logic [1:0]       r_bus_mode;
  logic [7:0]       w_da_nxt;
  logic [1:0]       w_mode_nxt;

  assign w_fifo_din = {bus_if.req_addr, bus_if.req_data};

  ay_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus_if.req_valid),
    .pop   (w_pop),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .level (w_fifo_level)
  );

`ifdef AY_BUS_WRITER_SKIP_LATCH_EN
  logic [3:0] r_last_addr;
  logic       r_last_valid;

  // Remember the register the PSG currently has latched, once a LATCH completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_addr  <= 4'h0;
      r_last_valid <= 1'b0;
    end else if (r_state == ST_LATCH && w_phase_done) begin
      r_last_addr  <= r_hold.addr;
      r_last_valid <= 1'b1;
    end
  end

  assign w_skip = r_last_valid && (w_fifo_dout.addr == r_last_addr);
`else
  assign w_skip = 1'b0;
`endif

  assign w_phase_done = (r_cnt == '0);

  // Next-state, phase counter reload and next bus pin values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_hold_nxt  = r_hold;
    w_da_nxt    = 8'h00;
    w_mode_nxt  = MODE_INACTIVE;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_hold_nxt  = w_fifo_dout;
          w_state_nxt = w_skip ? ST_WRITE : ST_LATCH;
          w_cnt_nxt   = C_HOLD_LOAD;
        end
      end
      ST_LATCH: begin
        if (w_phase_done) begin
          w_state_nxt = ST_GAP_A;
          w_cnt_nxt   = C_GAP_LOAD;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      ST_GAP_A: begin
        if (w_phase_done) begin
          w_state_nxt = ST_WRITE;
          w_cnt_nxt   = C_HOLD_LOAD;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      ST_WRITE: begin
        if (w_phase_done) begin
          w_state_nxt = ST_GAP_D;
          w_cnt_nxt   = C_GAP_LOAD;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      ST_GAP_D: begin
        if (!w_phase_done) begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end else if (!w_fifo_empty) begin
          // Back-to-back: start the next transaction without an IDLE cycle.
          w_pop       = 1'b1;
          w_hold_nxt  = w_fifo_dout;
          w_state_nxt = w_skip ? ST_WRITE : ST_LATCH;
          w_cnt_nxt   = C_HOLD_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Bus pins follow the state being entered so they change on the same edge.
    case (w_state_nxt)
      ST_LATCH: begin
        w_da_nxt   = {4'h0, w_hold_nxt.addr};
        w_mode_nxt = MODE_LATCH;
      end
      ST_WRITE: begin
        w_da_nxt   = w_hold_nxt.data;
        w_mode_nxt = MODE_WRITE;
      end
      default: begin
        w_da_nxt   = 8'h00;
        w_mode_nxt = MODE_INACTIVE;
      end
    endcase
  end

  // State, phase counter, held request and bus pin registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_bus_da   <= 8'h00;
      r_bus_mode <= MODE_INACTIVE;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hold     <= w_hold_nxt;
      r_bus_da   <= w_da_nxt;
      r_bus_mode <= w_mode_nxt;
    end
  end

  assign bus_if.req_ready  = !w_fifo_full;
  assign bus_if.bus_da     = r_bus_da;
  assign bus_if.bus_bdir   = r_bus_mode[1];
  assign bus_if.bus_bc1    = r_bus_mode[0];
  assign bus_if.busy       = (r_state != ST_IDLE) || !w_fifo_empty;
  assign bus_if.fifo_level = w_fifo_level;

endmodule
`default_nettype wire

// File: tb/tb_ay_bus_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ay_bus_writer
//  Description : Self-checking bench for ay_bus_writer. A bus monitor models
//                the PSG register file and pops expected writes from a
//                scoreboard queue filled when requests are accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ay_bus_writer;
  import ay_bus_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  ay_req_t    sb[$];
  int         wr_times[$];
  logic [7:0] psg_regs [16];
  logic [3:0] mon_addr;
  logic [1:0] prev_mode;
  logic [1:0] mon_mode;
  ay_req_t    mon_exp;

  ay_bus_writer_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus_if ();

  ay_bus_writer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .HOLD_CYCLES (2),
    .GAP_CYCLES  (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PSG-side model: latch address on mode 11, store data on the first cycle of mode 10.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_mode = MODE_INACTIVE;
    end else begin
      mon_mode = {bus_if.bus_bdir, bus_if.bus_bc1};
      if (mon_mode == MODE_LATCH) mon_addr = bus_if.bus_da[3:0];
      if (mon_mode == MODE_WRITE && prev_mode != MODE_WRITE) begin
        wr_times.push_back(cyc);
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL sb_unexpected_write: observed write %0h<=%0h expected none", mon_addr, bus_if.bus_da);
        end
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          check("sb_write", 32'({mon_addr, bus_if.bus_da}), 32'(mon_exp));
        end
        psg_regs[mon_addr] = bus_if.bus_da;
      end
      prev_mode = mon_mode;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds req_valid with the given request until it is accepted (bounded).
  task automatic push_req(input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = a;
    bus_if.req_data  = d;
    while (bus_if.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("push_ready_timeout", 32'(bus_if.req_ready), 32'd1);
    @(posedge clk);
    if (bus_if.req_ready === 1'b1) sb.push_back('{addr: a, data: d});
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (bus_if.busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(bus_if.busy), 32'd0);
  endtask

  // One R8 write from idle; counts LATCH cycles and busy cycles over the next 10 edges.
  task automatic measure(input logic [7:0] d, output int latch_n, output int busy_n);
    push_req(4'd8, d);
    bus_if.req_valid = 1'b0;
    latch_n = 0;
    busy_n  = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if ({bus_if.bus_bdir, bus_if.bus_bc1} == MODE_LATCH) latch_n++;
      if (bus_if.busy === 1'b1) busy_n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_mode [7];
    logic [7:0] exp_da   [7];
    int         n;
    int         latch_n;
    int         busy_n;

    for (int i = 0; i < 16; i++) psg_regs[i] = 8'h00;
    mon_addr  = 4'h0;
    prev_mode = MODE_INACTIVE;
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = 4'h0;
    bus_if.req_data  = 8'h00;
    reset = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_bdir",  32'(bus_if.bus_bdir),   32'd0);
    check("rst_bc1",   32'(bus_if.bus_bc1),    32'd0);
    check("rst_da",    32'(bus_if.bus_da),     32'h00);
    check("rst_busy",  32'(bus_if.busy),       32'd0);
    check("rst_level", 32'(bus_if.fifo_level), 32'd0);
    check("rst_ready", 32'(bus_if.req_ready),  32'd1);
    reset = 1'b0;
    tick();

    // Single request R7=0x38: exact cycle-by-cycle bus sequence
    exp_mode = '{MODE_LATCH, MODE_LATCH, MODE_INACTIVE, MODE_WRITE, MODE_WRITE, MODE_INACTIVE, MODE_INACTIVE};
    exp_da   = '{8'h07, 8'h07, 8'h00, 8'h38, 8'h38, 8'h00, 8'h00};
    push_req(4'd7, 8'h38);
    bus_if.req_valid = 1'b0;
    check("t2_busy_after_accept", 32'(bus_if.busy), 32'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("t2_mode_n%0d", k + 1), 32'({bus_if.bus_bdir, bus_if.bus_bc1}), 32'(exp_mode[k]));
      if (k < 5) check($sformatf("t2_da_n%0d", k + 1), 32'(bus_if.bus_da), 32'(exp_da[k]));
    end
    check("t2_busy_idle", 32'(bus_if.busy), 32'd0);
    repeat (2) tick();
    check("t2_busy_stays_low", 32'(bus_if.busy), 32'd0);

    // Back-to-back burst until the FIFO fills
    wr_times.delete();
    push_req(4'd0, 8'hFF);
    push_req(4'd1, 8'h01);
    push_req(4'd8, 8'h0F);
    push_req(4'd7, 8'h3E);
    push_req(4'd9, 8'h10);
    check("t3_level_full", 32'(bus_if.fifo_level), 32'd4);
    check("t3_ready_full", 32'(bus_if.req_ready),  32'd0);

    // Keep a request pending while full; it must enter only after a pop frees a slot
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 4'd10;
    bus_if.req_data  = 8'h0C;
    n = 0;
    while (bus_if.req_ready !== 1'b1 && n < 20) begin
      check("t4_level_while_blocked", 32'(bus_if.fifo_level), 32'd4);
      tick();
      n++;
    end
    check("t4_level_after_pop", 32'(bus_if.fifo_level), 32'd3);
    @(posedge clk);
    if (bus_if.req_ready === 1'b1) sb.push_back('{addr: 4'd10, data: 8'h0C});
    #1;
    bus_if.req_valid = 1'b0;
    check("t4_level_after_push", 32'(bus_if.fifo_level), 32'd4);
    wait_idle(200);
    check("t4_sb_drained", 32'(sb.size()), 32'd0);
    check("t3_txn_count", 32'(wr_times.size()), 32'd6);
    for (int i = 1; i < wr_times.size(); i++) begin
      check($sformatf("t3_txn_spacing_%0d", i), 32'(wr_times[i] - wr_times[i-1]), 32'd6);
    end

    // PSG register view: R7=0x3E enables tone A (active low bit 0), R8 amplitude 15
    check("t6_r7_value",     32'(psg_regs[7]),      32'h3E);
    check("t6_toneA_enable", 32'(psg_regs[7][0]),   32'd0);
    check("t6_ampA",         32'(psg_regs[8][3:0]), 32'hF);
    check("t6_ampA_fixed",   32'(psg_regs[8][4]),   32'd0);

    // Repeated writes to R8
    measure(8'h05, latch_n, busy_n);
    check("t5_first_latch", 32'(latch_n), 32'd2);
    check("t5_first_busy",  32'(busy_n),  32'd6);
    measure(8'h0A, latch_n, busy_n);
`ifdef AY_BUS_WRITER_SKIP_LATCH_EN
    check("t5_second_latch", 32'(latch_n), 32'd0);
    check("t5_second_busy",  32'(busy_n),  32'd3);
`else
    check("t5_second_latch", 32'(latch_n), 32'd2);
    check("t5_second_busy",  32'(busy_n),  32'd6);
`endif
    check("t5_r8_value", 32'(psg_regs[8]), 32'h0A);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    measure(8'h0B, latch_n, busy_n);
    check("t5_after_reset_latch", 32'(latch_n), 32'd2);
    check("t5_after_reset_busy",  32'(busy_n),  32'd6);

    // Reset asserted in the middle of a WRITE phase
    push_req(4'd3, 8'h55);
    push_req(4'd4, 8'h66);
    bus_if.req_valid = 1'b0;
    n = 0;
    while ({bus_if.bus_bdir, bus_if.bus_bc1} != MODE_WRITE && n < 20) begin
      tick();
      n++;
    end
    check("t1_reach_write", 32'({bus_if.bus_bdir, bus_if.bus_bc1}), 32'(MODE_WRITE));
    check("t1_level_before", 32'(bus_if.fifo_level), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t1_bdir",  32'(bus_if.bus_bdir),   32'd0);
    check("t1_bc1",   32'(bus_if.bus_bc1),    32'd0);
    check("t1_da",    32'(bus_if.bus_da),     32'h00);
    check("t1_level", 32'(bus_if.fifo_level), 32'd0);
    check("t1_ready", 32'(bus_if.req_ready),  32'd1);
    check("t1_busy",  32'(bus_if.busy),       32'd0);
    sb.delete();
    #2;
    reset = 1'b0;
    repeat (4) tick();
    check("t1_no_replay_busy", 32'(bus_if.busy), 32'd0);
    check("t1_no_replay_mode", 32'({bus_if.bus_bdir, bus_if.bus_bc1}), 32'(MODE_INACTIVE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
